axi_ar_req_arbiter: RTL and testbench
=====================================

// Module: axi_ar_req_arbiter
// PURPOSE
// - Read-address request stage for one initiator port of the AXI node: round-robin arbitrates AR requests
//   from N_TARG_PORT target ports onto a single AR channel toward one slave.
// - Prefixes each ARID with the winning target index so the response block can route R beats back by rid[MSB:AXI_ID_IN].
// - Registered output slice: 1-cycle request latency, full throughput (one AR per cycle).
// PARAMETERS
// - AXI_ADDRESS_W  32  address width
// - AXI_USER_W     6   aruser width
// - N_TARG_PORT    8   number of requesting target ports (>=2; non-power-of-2 allowed)
// - AXI_ID_IN      16  incoming ID width
// - AXI_ID_OUT     AXI_ID_IN+$clog2(N_TARG_PORT)  outgoing ID width
// PORTS
// - clk        in   1                          clock
// - rst_n      in   1                          async active-low reset
// - arvalid_i  in   N_TARG_PORT                per-target request valid
// - arready_o  out  N_TARG_PORT                per-target ready (one-hot or zero)
// - arid_i     in   N_TARG_PORT*AXI_ID_IN      packed IDs, port k at [k*AXI_ID_IN +: AXI_ID_IN]
// - araddr_i   in   N_TARG_PORT*AXI_ADDRESS_W  packed addresses
// - arlen_i    in   N_TARG_PORT*8              packed burst lengths
// - arsize_i   in   N_TARG_PORT*3              packed burst sizes
// - arburst_i  in   N_TARG_PORT*2              packed burst types
// - aruser_i   in   N_TARG_PORT*AXI_USER_W     packed user bits
// - arvalid_o  out  1                          request valid to slave
// - arready_i  in   1                          slave ready
// - arid_o     out  AXI_ID_OUT                 {winner index, arid}
// - araddr_o / arlen_o / arsize_o / arburst_o / aruser_o  out  widths as above  registered payload
// BEHAVIOUR
// - Clock clk; reset rst_n asynchronous, active-low. During/after reset: arvalid_o=0, all payload outputs=0,
//   arready_o=0 (combinationally, since slot empty and no requests honoured until rst_n high), rr_ptr=0.
// - Slot free: slot_free = !arvalid_o || arready_i.
// - Arbitration (combinational): if slot_free, winner g = first k with arvalid_i[k]=1 searching k=rr_ptr,
//   rr_ptr+1, ... wrapping at N_TARG_PORT-1 -> 0. arready_o = onehot(g); else arready_o=0.
// - Accept: on arvalid_i[g]&&arready_o[g]: next edge loads payload of g, arid_o <= {g[$clog2(N_TARG_PORT)-1:0], arid_g},
//   arvalid_o <= 1, rr_ptr <= (g==N_TARG_PORT-1) ? 0 : g+1.
// - No accept and arready_i=1: arvalid_o <= 0, payload held. rr_ptr changes only on accept.
// - Stall (arvalid_o=1, arready_i=0): all outputs held stable; arready_o=0 (AXI stability rule).
// - Simultaneous drain + accept in same cycle: allowed, back-to-back transfers with no bubble.
// - arready_o may depend combinationally on arvalid_i and arready_i; arvalid_o never depends on arready_i.
// - Fairness: a continuously requesting port is granted within N_TARG_PORT accepts.
// - Upstream withdrawing arvalid_i before handshake is an AXI violation; behaviour undefined, not checked.
// - Reset mid-transfer: pending registered request discarded, arvalid_o drops asynchronously.
// STRUCTURE
// - Shared package/include axi_node_pkg: AXI burst/resp encodings, function for index width (clog2 with min 1).
// - One sub-module: axi_rr_arb (N-way round-robin: req vector, ptr, enable -> one-hot gnt + binary index,
//   rr pointer register inside, updated on enable&&|req). Reused later for AW arbitration.
// - Top: packed-bus slicing by generate loop, payload mux by binary index, output register slice.
// TESTING
// - Reset: hold rst_n=0 with all arvalid_i=1 -> arvalid_o=0, arready_o=0, arid_o=0; release -> port 0 granted first.
// - Single request: N=8, port 5 arid=16'h00A3, addr=32'h1000_0040, arready_i=1 -> next cycle arvalid_o=1,
//   arid_o=19'h5_00A3, araddr_o=32'h1000_0040; arready_o=8'b0010_0000 in request cycle.
// - Round-robin: all 8 ports request continuously, arready_i=1 -> grant order 0,1,...,7,0 one per cycle, no bubbles.
// - Backpressure: arready_i=0 for 5 cycles with ports 2,3 pending -> arvalid_o held with port 2 payload, arready_o=0;
//   release -> port 2 handshake, port 3 accepted same cycle, issued next cycle.
// - Wrap, N_TARG_PORT=5: rr_ptr=4, requests on ports 1 and 4 -> 4 granted, then 1; arid_o prefix 3'd4 then 3'd1.
// - Async reset while arvalid_o=1, arready_i=0 -> arvalid_o=0 immediately; after release rr_ptr=0.

Source files
------------

// File: rtl/axi_node_pkg.sv
// axi_node_pkg: shared AXI node encodings and index-width helper
package axi_node_pkg;
  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} axi_burst_e;
  typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} axi_resp_e;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/axi_rr_arb.sv
// axi_rr_arb: N-way round-robin arbiter (req/en in, one-hot gnt + binary idx out, pointer advances past each grant)
module axi_rr_arb
  import axi_node_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr;
  logic          found;
  always_comb begin
    idx   = '0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < N; k++)
      if (!found && req[k] && int'(ptr) <= k) begin
        idx   = IW'(k);
        found = 1'b1;
      end
    for (int k = 0; k < N; k++)
      if (!found && req[k]) begin
        idx   = IW'(k);
        found = 1'b1;
      end
    for (int k = 0; k < N; k++)
      gnt[k] = en && req[k] && idx == IW'(k);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (en && found) ptr <= (int'(idx) == N - 1) ? '0 : idx + IW'(1);
endmodule

// File: rtl/axi_ar_req_arbiter.sv
// axi_ar_req_arbiter: round-robin AR arbiter of N_TARG_PORT targets onto one registered AR channel; arid_o = {winner, arid}
module axi_ar_req_arbiter
  import axi_node_pkg::*;
#(
  parameter int AXI_ADDRESS_W = 32,
  parameter int AXI_USER_W    = 6,
  parameter int N_TARG_PORT   = 8,
  parameter int AXI_ID_IN     = 16,
  parameter int AXI_ID_OUT    = AXI_ID_IN + $clog2(N_TARG_PORT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_TARG_PORT-1:0]               arvalid_i,
  output logic [N_TARG_PORT-1:0]               arready_o,
  input  logic [N_TARG_PORT*AXI_ID_IN-1:0]     arid_i,
  input  logic [N_TARG_PORT*AXI_ADDRESS_W-1:0] araddr_i,
  input  logic [N_TARG_PORT*8-1:0]             arlen_i,
  input  logic [N_TARG_PORT*3-1:0]             arsize_i,
  input  logic [N_TARG_PORT*2-1:0]             arburst_i,
  input  logic [N_TARG_PORT*AXI_USER_W-1:0]    aruser_i,
  output logic                                 arvalid_o,
  input  logic                                 arready_i,
  output logic [AXI_ID_OUT-1:0]                arid_o,
  output logic [AXI_ADDRESS_W-1:0]             araddr_o,
  output logic [7:0]                           arlen_o,
  output logic [2:0]                           arsize_o,
  output logic [1:0]                           arburst_o,
  output logic [AXI_USER_W-1:0]                aruser_o
);
  localparam int IW = idx_w(N_TARG_PORT);
  logic [AXI_ID_IN-1:0]     id_a   [N_TARG_PORT];
  logic [AXI_ADDRESS_W-1:0] addr_a [N_TARG_PORT];
  logic [7:0]               len_a  [N_TARG_PORT];
  logic [2:0]               size_a [N_TARG_PORT];
  logic [1:0]               burst_a[N_TARG_PORT];
  logic [AXI_USER_W-1:0]    user_a [N_TARG_PORT];
  logic [IW-1:0]            idx;
  logic                     slot_free;
  for (genvar g = 0; g < N_TARG_PORT; g++) begin : g_slice
    assign id_a[g]    = arid_i[g*AXI_ID_IN +: AXI_ID_IN];
    assign addr_a[g]  = araddr_i[g*AXI_ADDRESS_W +: AXI_ADDRESS_W];
    assign len_a[g]   = arlen_i[g*8 +: 8];
    assign size_a[g]  = arsize_i[g*3 +: 3];
    assign burst_a[g] = arburst_i[g*2 +: 2];
    assign user_a[g]  = aruser_i[g*AXI_USER_W +: AXI_USER_W];
  end
  assign slot_free = rst_n && (!arvalid_o || arready_i);
  axi_rr_arb #(.N(N_TARG_PORT), .IW(IW)) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (arvalid_i),
    .en   (slot_free),
    .gnt  (arready_o),
    .idx  (idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      arvalid_o <= 1'b0;
      arid_o    <= '0;
      araddr_o  <= '0;
      arlen_o   <= '0;
      arsize_o  <= '0;
      arburst_o <= '0;
      aruser_o  <= '0;
    end else if (|arready_o) begin
      arvalid_o <= 1'b1;
      arid_o    <= {idx, id_a[idx]};
      araddr_o  <= addr_a[idx];
      arlen_o   <= len_a[idx];
      arsize_o  <= size_a[idx];
      arburst_o <= burst_a[idx];
      aruser_o  <= user_a[idx];
    end else if (arready_i) arvalid_o <= 1'b0;
endmodule

// File: tb/tb_axi_ar_req_arbiter.sv
// tb_axi_ar_req_arbiter: directed + randomized checks of axi_ar_req_arbiter (N=8) and a wrap check at N=5
module tb_axi_ar_req_arbiter;
  localparam int N = 8, IDW = 16, AW = 32, UW = 6, OW = 19;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic              rst_n;
  logic [N-1:0]      arvalid_i, arready_o;
  logic [N*IDW-1:0]  arid_i;
  logic [N*AW-1:0]   araddr_i;
  logic [N*8-1:0]    arlen_i;
  logic [N*3-1:0]    arsize_i;
  logic [N*2-1:0]    arburst_i;
  logic [N*UW-1:0]   aruser_i;
  logic              arvalid_o, arready_i;
  logic [OW-1:0]     arid_o;
  logic [AW-1:0]     araddr_o;
  logic [7:0]        arlen_o;
  logic [2:0]        arsize_o;
  logic [1:0]        arburst_o;
  logic [UW-1:0]     aruser_o;
  axi_ar_req_arbiter dut (
    .clk(clk), .rst_n(rst_n), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .aruser_i(aruser_i), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .aruser_o(aruser_o)
  );
  logic [4:0]   v5, r5;
  logic [19:0]  id5;
  logic [159:0] addr5 = '0;
  logic [39:0]  len5 = '0;
  logic [14:0]  size5 = '0;
  logic [9:0]   burst5 = '0;
  logic [29:0]  user5 = '0;
  logic         o5v, o5r;
  logic [6:0]   o5id;
  logic [31:0]  o5addr;
  logic [7:0]   o5len;
  logic [2:0]   o5size;
  logic [1:0]   o5burst;
  logic [5:0]   o5user;
  axi_ar_req_arbiter #(.N_TARG_PORT(5), .AXI_ID_IN(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .arvalid_i(v5), .arready_o(r5),
    .arid_i(id5), .araddr_i(addr5), .arlen_i(len5), .arsize_i(size5),
    .arburst_i(burst5), .aruser_i(user5), .arvalid_o(o5v), .arready_i(o5r),
    .arid_o(o5id), .araddr_o(o5addr), .arlen_o(o5len), .arsize_o(o5size),
    .arburst_o(o5burst), .aruser_o(o5user)
  );
  bit          req[N];
  logic [15:0] mid[N];
  logic [31:0] maddr[N];
  logic [7:0]  mlen[N];
  logic [2:0]  msz[N];
  logic [1:0]  mb[N];
  logic [5:0]  mu[N];
  bit          ardy, ev;
  int          ptr;
  logic [OW-1:0] eid;
  logic [31:0] eaddr;
  logic [7:0]  elen;
  logic [2:0]  esz;
  logic [1:0]  eb;
  logic [5:0]  eu;
  int cmps = 0, errs = 0;
  int g;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic newreq(input int k);
    req[k] = 1'b1;
    mid[k] = 16'($urandom);
    maddr[k] = $urandom;
    mlen[k] = 8'($urandom);
    msz[k] = 3'($urandom);
    mb[k] = 2'($urandom_range(0, 2));
    mu[k] = 6'($urandom);
  endtask
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      arvalid_i[k] = req[k];
      arid_i[k*IDW +: IDW] = mid[k];
      araddr_i[k*AW +: AW] = maddr[k];
      arlen_i[k*8 +: 8] = mlen[k];
      arsize_i[k*3 +: 3] = msz[k];
      arburst_i[k*2 +: 2] = mb[k];
      aruser_i[k*UW +: UW] = mu[k];
    end
    arready_i = ardy;
  endtask
  task automatic mreset();
    ev = 1'b0; ptr = 0; eid = '0; eaddr = '0; elen = '0; esz = '0; eb = '0; eu = '0;
  endtask
  // one clock: starts and ends on a falling edge
  task automatic cycle(output int gw);
    logic [N-1:0] oh;
    drive();
    #1;
    gw = -1;
    if (!ev || ardy)
      for (int i = 0; i < N; i++)
        if (gw < 0 && req[(ptr + i) % N]) gw = (ptr + i) % N;
    oh = '0;
    if (gw >= 0) oh[gw] = 1'b1;
    chk("arready_o", 64'(arready_o), 64'(oh));
    @(posedge clk);
    if (gw >= 0) begin
      ev = 1'b1;
      eid = {3'(gw), mid[gw]};
      eaddr = maddr[gw]; elen = mlen[gw]; esz = msz[gw]; eb = mb[gw]; eu = mu[gw];
      ptr = (gw + 1) % N;
      req[gw] = 1'b0;
    end else if (ardy) ev = 1'b0;
    #1;
    chk("arvalid_o", 64'(arvalid_o), 64'(ev));
    chk("arid_o", 64'(arid_o), 64'(eid));
    chk("araddr_o", 64'(araddr_o), 64'(eaddr));
    chk("arlen_o", 64'(arlen_o), 64'(elen));
    chk("arsize_o", 64'(arsize_o), 64'(esz));
    chk("arburst_o", 64'(arburst_o), 64'(eb));
    chk("aruser_o", 64'(aruser_o), 64'(eu));
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    v5 = '0; id5 = '0; o5r = 1'b1;
    ardy = 1'b1;
    mreset();
    for (int k = 0; k < N; k++) newreq(k);
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", 64'(arvalid_o), 64'(0));
    chk("rst_arready", 64'(arready_o), 64'(0));
    chk("rst_arid", 64'(arid_o), 64'(0));
    chk("rst_araddr", 64'(araddr_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      for (int k = 0; k < N; k++) if (!req[k]) newreq(k);
      cycle(g);
      chk("rr_grant", 64'(g), 64'(c % N));
      chk("rr_nobubble", 64'(arvalid_o), 64'(1));
    end
    for (int k = 0; k < N; k++) req[k] = 1'b0;
    req[5] = 1'b1; mid[5] = 16'h00A3; maddr[5] = 32'h1000_0040;
    drive();
    #1;
    chk("single_arready", 64'(arready_o), 64'(8'b0010_0000));
    cycle(g);
    chk("single_arid", 64'(arid_o), 64'(19'h5_00A3));
    chk("single_araddr", 64'(araddr_o), 64'(32'h1000_0040));
    cycle(g);
    chk("drain_arvalid", 64'(arvalid_o), 64'(0));
    newreq(2); newreq(3);
    ardy = 1'b0;
    cycle(g);
    chk("bp_first", 64'(g), 64'(2));
    repeat (5) begin
      cycle(g);
      chk("bp_nogrant", 64'(g), -64'(1));
      chk("bp_hold_valid", 64'(arvalid_o), 64'(1));
      chk("bp_hold_prefix", 64'(arid_o[18:16]), 64'(2));
    end
    ardy = 1'b1;
    cycle(g);
    chk("bp_release", 64'(g), 64'(3));
    chk("bp_next_prefix", 64'(arid_o[18:16]), 64'(3));
    ardy = 1'b0;
    cycle(g);
    newreq(1);
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_arvalid", 64'(arvalid_o), 64'(0));
    chk("async_arready", 64'(arready_o), 64'(0));
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    newreq(3); newreq(6);
    ardy = 1'b1;
    cycle(g);
    chk("post_rst_ptr0", 64'(g), 64'(1));
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) if (!req[k] && $urandom_range(0, 2) == 0) newreq(k);
      ardy = $urandom_range(0, 3) != 0;
      cycle(g);
    end
    for (int k = 0; k < N; k++) req[k] = 1'b0;
    ardy = 1'b1;
    cycle(g);
    cycle(g);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v5 = 5'b01000; id5[12 +: 4] = 4'h3; id5[4 +: 4] = 4'h1; id5[16 +: 4] = 4'h4;
    #1;
    chk("n5_first_gnt", 64'(r5), 64'(5'b01000));
    @(posedge clk);
    #1;
    chk("n5_first_id", 64'(o5id), 64'(7'h33));
    @(negedge clk);
    v5 = 5'b00000;
    @(negedge clk);
    v5 = 5'b10010;
    #1;
    chk("n5_wrap_gnt4", 64'(r5), 64'(5'b10000));
    @(posedge clk);
    #1;
    chk("n5_wrap_id4", 64'(o5id), 64'(7'h44));
    @(negedge clk);
    v5 = 5'b00010;
    #1;
    chk("n5_wrap_gnt1", 64'(r5), 64'(5'b00010));
    @(posedge clk);
    #1;
    chk("n5_wrap_id1", 64'(o5id), 64'(7'h11));
    @(negedge clk);
    v5 = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
